// File: rtl/ahb_intc.sv
`default_nettype none
//------------------------------------------------------------------------------
// ahb_intc - latching, masking, fixed-priority interrupt controller on the
// single-cycle register bus; presents one irq/irq_id to the CPU.   Rev 1.0
//------------------------------------------------------------------------------
module ahb_intc #(
  parameter int NSRC = 8
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [4:2]      HADDR,
  input  logic            HWRITE,
  input  logic [31:0]     HWDATA,
  output logic [31:0]     HRDATA,
  input  logic [NSRC-1:0] irq_src,
  input  logic            irq_ack,
  output logic            irq,
  output logic [2:0]      irq_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] A_RAW     = 3'd0;
  localparam logic [2:0] A_PENDING = 3'd1;
  localparam logic [2:0] A_ENABLE  = 3'd2;
  localparam logic [2:0] A_EDGE    = 3'd3;
  localparam logic [2:0] A_ACTIVE  = 3'd4;
  localparam logic [2:0] A_EOI     = 3'd5;
  localparam logic [2:0] A_SWSET   = 3'd6;

  state_t          state, state_nxt;
  logic [NSRC-1:0] src_q, pending, enable, edge_sel;
  logic [NSRC-1:0] rise, set_term, clr_term, pending_nxt, eligible, id_onehot;
  logic            wr, eoi_wr, ack_clr, id_eligible;
  logic            irq_nxt, act_valid, act_valid_nxt;
  logic [2:0]      irq_id_nxt, act_id, act_id_nxt, lowest_id;
  logic [31:0]     rdata;
  logic            unused_hwdata;

  assign wr            = HSEL & HWRITE;
  assign eoi_wr        = wr && (HADDR == A_EOI);
  assign unused_hwdata = ^HWDATA[31:NSRC];

  assign rise     = irq_src & ~src_q;
  assign eligible = pending & enable;

  always_comb begin
    id_onehot = '0;
    lowest_id = '0;
    for (int i = 0; i < NSRC; i++) begin
      id_onehot[i] = (irq_id == 3'(i));
    end
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) lowest_id = 3'(i);
    end
  end

  assign id_eligible = |(eligible & id_onehot);

  // Set is applied after clear so a still-asserted source wins the same cycle.
  always_comb begin
    set_term = (edge_sel & rise) | (~edge_sel & irq_src);
    clr_term = ack_clr ? id_onehot : '0;
    if (wr && (HADDR == A_SWSET))   set_term = set_term | HWDATA[NSRC-1:0];
    if (wr && (HADDR == A_PENDING)) clr_term = clr_term | HWDATA[NSRC-1:0];
    pending_nxt = (pending & ~clr_term) | set_term;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src_q    <= '0;
      pending  <= '0;
      enable   <= '0;
      edge_sel <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= pending_nxt;
      if (wr && (HADDR == A_ENABLE)) enable   <= HWDATA[NSRC-1:0];
      if (wr && (HADDR == A_EDGE))   edge_sel <= HWDATA[NSRC-1:0];
    end
  end

  // irq_id is captured on entry to REQ and held until the request resolves.
  always_comb begin
    state_nxt     = state;
    irq_nxt       = irq;
    irq_id_nxt    = irq_id;
    act_valid_nxt = act_valid;
    act_id_nxt    = act_id;
    ack_clr       = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt  = REQ;
          irq_nxt    = 1'b1;
          irq_id_nxt = lowest_id;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_nxt     = SERVICE;
          irq_nxt       = 1'b0;
          ack_clr       = 1'b1;
          act_valid_nxt = 1'b1;
          act_id_nxt    = irq_id;
        end else if (!id_eligible) begin
          state_nxt = IDLE;
          irq_nxt   = 1'b0;
        end
      end
      SERVICE: begin
        irq_nxt = 1'b0;
        if (eoi_wr) begin
          state_nxt     = IDLE;
          act_valid_nxt = 1'b0;
          act_id_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        irq_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      irq       <= 1'b0;
      irq_id    <= '0;
      act_valid <= 1'b0;
      act_id    <= '0;
    end else begin
      state     <= state_nxt;
      irq       <= irq_nxt;
      irq_id    <= irq_id_nxt;
      act_valid <= act_valid_nxt;
      act_id    <= act_id_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    case (HADDR)
      A_RAW:     rdata[NSRC-1:0] = irq_src;
      A_PENDING: rdata[NSRC-1:0] = pending;
      A_ENABLE:  rdata[NSRC-1:0] = enable;
      A_EDGE:    rdata[NSRC-1:0] = edge_sel;
      A_ACTIVE:  rdata = {act_valid, 28'd0, act_id};
      default:   rdata = '0;
    endcase
  end

  assign HRDATA = rdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_intc.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_ahb_intc - directed scoreboard bench for ahb_intc.   Rev 1.0
//------------------------------------------------------------------------------
module tb_ahb_intc;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [4:2]  HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic [7:0]  irq_src = '0;
  logic        irq_ack = 1'b0;
  logic        irq;
  logic [2:0]  irq_id;

  ahb_intc #(.NSRC(8)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .HSEL    (HSEL),
    .HADDR   (HADDR),
    .HWRITE  (HWRITE),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .irq_src (irq_src),
    .irq_ack (irq_ack),
    .irq     (irq),
    .irq_id  (irq_id)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    int          kind;   // 0: HRDATA, 1: irq, 2: irq_id
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  logic probe = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Monitor: every probed cycle, drain the expectations queued for it.
  always @(negedge HCLK) begin
    if (probe) begin
      while (q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = q.pop_front();
        case (e.kind)
          0:       act = HRDATA;
          1:       act = {31'd0, irq};
          default: act = {29'd0, irq_id};
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic probe_tick();
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic exp_rd(input string n, input logic [2:0] a, input logic [31:0] v);
    HADDR = a;
    q.push_back('{n, 0, v});
  endtask

  task automatic exp_irq(input string n, input logic v, input logic [2:0] id);
    q.push_back('{{n, ".irq"}, 1, {31'd0, v}});
    q.push_back('{{n, ".id"}, 2, {29'd0, id}});
  endtask

  task automatic exp_irq_only(input string n, input logic v);
    q.push_back('{{n, ".irq"}, 1, {31'd0, v}});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    HSEL = 1'b1; HWRITE = 1'b1; HADDR = a; HWDATA = d;
    tick();
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = '0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    tick();

    // Reset state
    exp_irq("reset", 1'b0, 3'd0);
    for (int a = 0; a < 8; a++) begin
      exp_rd($sformatf("reset.rd%0d", a), 3'(a), 32'd0);
      probe_tick();
    end

    // Edge-mode single source, ack, EOI
    wr(3'd2, 32'h0F);
    wr(3'd3, 32'h0F);
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    exp_rd("edge.pending", 3'd1, 32'h04);
    exp_irq_only("edge.pre", 1'b0);
    probe_tick();
    exp_irq("edge.req", 1'b1, 3'd2);
    probe_tick();
    ack_pulse();
    exp_irq_only("edge.acked", 1'b0);
    exp_rd("edge.active", 3'd4, 32'h8000_0002);
    probe_tick();
    exp_rd("edge.pend_clr", 3'd1, 32'h00);
    probe_tick();
    wr(3'd5, 32'h1);
    exp_rd("edge.eoi_active", 3'd4, 32'h0);
    exp_irq_only("edge.eoi", 1'b0);
    probe_tick();

    // Priority: src1 beats src5
    wr(3'd2, 32'hFF);
    irq_src = 8'h22;
    tick();
    irq_src = 8'h00;
    tick();
    exp_irq("prio.first", 1'b1, 3'd1);
    probe_tick();
    ack_pulse();
    wr(3'd5, 32'h0);
    tick();
    exp_irq("prio.second", 1'b1, 3'd5);
    probe_tick();
    ack_pulse();
    wr(3'd5, 32'h0);

    // Frozen id while in REQ
    irq_src = 8'h40;
    tick();
    irq_src = 8'h00;
    tick();
    exp_irq("frozen.first", 1'b1, 3'd6);
    probe_tick();
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    exp_irq("frozen.hold", 1'b1, 3'd6);
    exp_rd("frozen.pending", 3'd1, 32'h41);
    probe_tick();
    ack_pulse();
    wr(3'd5, 32'h0);
    tick();
    exp_irq("frozen.next", 1'b1, 3'd0);
    probe_tick();
    ack_pulse();
    wr(3'd5, 32'h0);

    // Withdraw by software clear
    wr(3'd2, 32'h08);
    irq_src = 8'h08;
    tick();
    tick();
    exp_irq("wd.req", 1'b1, 3'd3);
    probe_tick();
    wr(3'd1, 32'h08);
    exp_irq_only("wd.still", 1'b1);
    exp_rd("wd.pend_clr", 3'd1, 32'h0);
    probe_tick();
    exp_irq_only("wd.gone", 1'b0);
    exp_rd("wd.no_service", 3'd4, 32'h0);
    probe_tick();
    ack_pulse();
    exp_irq_only("wd.stray_ack", 1'b0);
    exp_rd("wd.stray_active", 3'd4, 32'h0);
    probe_tick();
    irq_src = 8'h00;

    // Level re-pend with simultaneous ack and W1C
    wr(3'd3, 32'h00);
    wr(3'd2, 32'h01);
    irq_src = 8'h01;
    tick();
    tick();
    exp_irq("lvl.req", 1'b1, 3'd0);
    exp_rd("lvl.raw", 3'd0, 32'h01);
    probe_tick();
    irq_ack = 1'b1; HSEL = 1'b1; HWRITE = 1'b1; HADDR = 3'd1; HWDATA = 32'h01;
    tick();
    irq_ack = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HWDATA = '0;
    exp_rd("lvl.repend", 3'd1, 32'h01);
    exp_irq_only("lvl.service", 1'b0);
    probe_tick();
    exp_rd("lvl.active", 3'd4, 32'h8000_0000);
    probe_tick();
    irq_src = 8'h00;
    wr(3'd1, 32'h01);
    wr(3'd5, 32'h0);
    exp_rd("lvl.cleared", 3'd1, 32'h0);
    exp_irq_only("lvl.idle", 1'b0);
    probe_tick();

    // Software set
    wr(3'd6, 32'h80);
    wr(3'd2, 32'h80);
    tick();
    exp_irq("swset.req", 1'b1, 3'd7);
    exp_rd("swset.pending", 3'd1, 32'h80);
    probe_tick();
    exp_rd("swset.reads0", 3'd6, 32'h0);
    probe_tick();
    exp_rd("swset.enable", 3'd2, 32'h80);
    probe_tick();
    exp_rd("swset.edge", 3'd3, 32'h0);
    probe_tick();
    exp_rd("swset.addr7", 3'd7, 32'h0);
    probe_tick();

    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
